// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: owner codes (also used by the hazard
// unit's stall logic), arbiter FSM states and default timing parameters.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_IDLE  = 2'b00,
        OWNER_CPU   = 2'b01,
        OWNER_SPART = 2'b10,
        OWNER_AUDIO = 2'b11
    } mem_owner_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } arb_state_t;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational winner selection: Audio > SPART > CPU, with a starving CPU
// promoted to the top and the current owner excluded from re-arbitration.
module mem_arb_select
    import mem_arbiter_pkg::*;
(
    input  logic       cpu_req,
    input  logic       spart_req,
    input  logic       audio_req,
    input  logic       starve_hit,
    input  mem_owner_t exclude,
    output mem_owner_t winner
);

    logic cpu_ok;
    logic spart_ok;
    logic audio_ok;

    always_comb begin
        cpu_ok   = cpu_req   && (exclude != OWNER_CPU);
        spart_ok = spart_req && (exclude != OWNER_SPART);
        audio_ok = audio_req && (exclude != OWNER_AUDIO);
        winner   = OWNER_IDLE;
        if (cpu_ok && starve_hit) begin
            winner = OWNER_CPU;
        end else if (audio_ok) begin
            winner = OWNER_AUDIO;
        end else if (spart_ok) begin
            winner = OWNER_SPART;
        end else if (cpu_ok) begin
            winner = OWNER_CPU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter (CPU, SPART, Audio) in front of a single synchronous RAM
// with fixed MEM_LAT latency; one transaction at a time, back-to-back grants.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    input  logic        spart_req,
    input  logic        spart_we,
    input  logic [15:0] spart_addr,
    input  logic [31:0] spart_wdata,
    output logic        spart_ack,
    input  logic        audio_req,
    input  logic [15:0] audio_addr,
    output logic        audio_ack,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  mem_busy
);

    localparam logic [2:0] LAT_TOP = 3'(MEM_LAT - 1);
    localparam int         SW      = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t    state;
    arb_state_t    state_nxt;
    mem_owner_t    owner;
    mem_owner_t    winner;
    mem_owner_t    exclude;
    logic [2:0]    cnt;
    logic [15:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_we;
    logic [SW-1:0] starve;
    logic          arbitrate;
    logic          grant;
    logic          starve_hit;

    // The same selector serves IDLE and RESP; in RESP the finishing owner is masked.
    assign arbitrate  = (state == ST_IDLE) || (state == ST_RESP);
    assign exclude    = (state == ST_RESP) ? owner : OWNER_IDLE;
    assign starve_hit = (starve == STARVE_TOP);
    assign grant      = arbitrate && (winner != OWNER_IDLE);

    mem_arb_select u_select (
        .cpu_req    (cpu_req),
        .spart_req  (spart_req),
        .audio_req  (audio_req),
        .starve_hit (starve_hit),
        .exclude    (exclude),
        .winner     (winner)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (grant) state_nxt = ST_ACCESS;
            ST_ACCESS: if (cnt == 3'd0) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = grant ? ST_ACCESS : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWNER_IDLE;
            cnt       <= 3'd0;
            lat_addr  <= 16'd0;
            lat_wdata <= 32'd0;
            lat_we    <= 1'b0;
            starve    <= '0;
            rdata     <= 32'd0;
        end else begin
            if (grant) begin
                owner <= winner;
                cnt   <= LAT_TOP;
                case (winner)
                    OWNER_CPU: begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        lat_we    <= cpu_we;
                    end
                    OWNER_SPART: begin
                        lat_addr  <= spart_addr;
                        lat_wdata <= spart_wdata;
                        lat_we    <= spart_we;
                    end
                    default: begin
                        lat_addr  <= audio_addr;
                        lat_wdata <= 32'd0;
                        lat_we    <= 1'b0;
                    end
                endcase
            end else if (state == ST_ACCESS) begin
                if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                end else if (!lat_we) begin
                    rdata <= mem_rdata;
                end
            end
            // Counts only lost grants while the CPU is actually waiting.
            if ((grant && (winner == OWNER_CPU)) || !cpu_req) begin
                starve <= '0;
            end else if (grant && !starve_hit) begin
                starve <= starve + 1'b1;
            end
        end
    end

    assign mem_busy  = (state == ST_IDLE) ? OWNER_IDLE : owner;
    assign mem_en    = (state == ST_ACCESS) && (cnt == LAT_TOP);
    assign mem_we    = mem_en && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign cpu_ack   = (state == ST_RESP) && (owner == OWNER_CPU);
    assign spart_ack = (state == ST_RESP) && (owner == OWNER_SPART);
    assign audio_ack = (state == ST_RESP) && (owner == OWNER_AUDIO);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model (service countdown per grant,
// priority rule, memory image) checked every cycle, plus directed scenarios.
module tb_mem_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, spart_req, spart_we, audio_req;
    logic [15:0] cpu_addr, spart_addr, audio_addr;
    logic [31:0] cpu_wdata, spart_wdata;
    logic        cpu_ack, spart_ack, audio_ack;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [1:0]  mem_busy;

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .spart_req(spart_req), .spart_we(spart_we), .spart_addr(spart_addr), .spart_wdata(spart_wdata),
        .spart_ack(spart_ack),
        .audio_req(audio_req), .audio_addr(audio_addr), .audio_ack(audio_ack),
        .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_busy(mem_busy)
    );

    // Synchronous RAM: read data registered one edge after mem_en, captured by the DUT at the next.
    logic [31:0] ram [65536];
    logic [31:0] rd_reg;
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            rd_reg <= ram[mem_addr];
        end
    end
    assign mem_rdata = rd_reg;

    // Reference model state
    logic [31:0] model_mem [65536];
    int          busy_left, own, starve;
    logic [15:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [31:0] exp_rdata;
    logic [2:0]  just_acked;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [1:0]  busy_q[$];
    logic [2:0]  ack_q[$];
    logic [31:0] rdata_q[$];
    logic [1:0]  en_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Priority rule: starving CPU first, then Audio > SPART > CPU; owner excluded.
    function automatic int pick(input logic c, input logic s, input logic a, input int excl, input bit hit);
        bit cv, sv, av;
        cv = c && (excl != 1);
        sv = s && (excl != 2);
        av = a && (excl != 3);
        if (cv && hit) return 1;
        if (av) return 3;
        if (sv) return 2;
        if (cv) return 1;
        return 0;
    endfunction

    task automatic cycle_run();
        int         e_busy, w;
        logic [2:0] e_ack, got_ack;
        @(negedge clk);
        got_ack = {audio_ack, spart_ack, cpu_ack};
        busy_q.push_back(mem_busy);
        ack_q.push_back(got_ack);
        rdata_q.push_back(rdata);
        en_q.push_back({mem_en, mem_we});
        e_ack = 3'b000;
        if (rst) begin
            busy_left = 0;
            starve    = 0;
            exp_rdata = 32'd0;
            chk("rst_busy", 64'(mem_busy), 64'd0);
            chk("rst_ack", 64'(got_ack), 64'd0);
            chk("rst_en_we", 64'({mem_en, mem_we}), 64'd0);
            chk("rst_rdata", 64'(rdata), 64'd0);
        end else begin
            e_busy = (busy_left > 0) ? own : 0;
            if (busy_left == 1) e_ack = 3'(1 << (own - 1));
            chk("busy", 64'(mem_busy), 64'(e_busy));
            chk("ack", 64'(got_ack), 64'(e_ack));
            chk("mem_en", 64'(mem_en), 64'(busy_left == LAT + 1));
            chk("mem_we", 64'(mem_we), 64'((busy_left == LAT + 1) && m_we));
            if (busy_left > 1) chk("mem_addr", 64'(mem_addr), 64'(m_addr));
            if (busy_left > 1 && m_we) chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
            chk("rdata", 64'(rdata), 64'(exp_rdata));
            if (busy_left <= 1) begin
                w = pick(cpu_req, spart_req, audio_req, (busy_left == 1) ? own : 0, starve == SMAX);
                if (w == 1 || !cpu_req) starve = 0;
                else if (w != 0 && starve < SMAX) starve++;
                if (w != 0) begin
                    own       = w;
                    busy_left = LAT + 1;
                    case (w)
                        1: begin m_addr = cpu_addr;   m_wdata = cpu_wdata;   m_we = cpu_we;   end
                        2: begin m_addr = spart_addr; m_wdata = spart_wdata; m_we = spart_we; end
                        default: begin m_addr = audio_addr; m_wdata = 32'd0; m_we = 1'b0; end
                    endcase
                    if (m_we) model_mem[m_addr] = m_wdata;
                end else begin
                    busy_left = 0;
                end
            end else begin
                if (!cpu_req) starve = 0;
                busy_left--;
                if (busy_left == 1 && !m_we) exp_rdata = model_mem[m_addr];
            end
        end
        @(posedge clk);
        #1;
        if (e_ack[0]) cpu_req = 1'b0;
        if (e_ack[1]) spart_req = 1'b0;
        if (e_ack[2]) audio_req = 1'b0;
        just_acked = e_ack;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, t1, n;
        rst = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        spart_req = 0; spart_we = 0; spart_addr = 0; spart_wdata = 0;
        audio_req = 0; audio_addr = 0;
        busy_left = 0; own = 0; starve = 0; exp_rdata = 0;
        m_addr = 0; m_wdata = 0; m_we = 0; just_acked = 0;
        for (int i = 0; i < 65536; i++) begin
            ram[i]       = $urandom;
            model_mem[i] = ram[i];
        end
        ram[16'h0010] = 32'hDEADBEEF; model_mem[16'h0010] = 32'hDEADBEEF;
        ram[16'h0100] = 32'd0;        model_mem[16'h0100] = 32'd0;

        @(posedge clk); #1;
        cycle_run(); cycle_run();
        rst = 1'b0;
        cycle_run(); cycle_run();

        // CPU read of a known word
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        t0 = busy_q.size();
        repeat (6) cycle_run();
        n = 0;
        for (int i = t0; i < t0 + 6; i++) if (busy_q[i] == 2'b01) n++;
        chk("rd_busy_cycles", 64'(n), 64'd3);
        chk("rd_ack_time", 64'(ack_q[t0 + 3]), 64'b001);
        chk("rd_data", 64'(rdata_q[t0 + 3]), 64'hDEADBEEF);

        // SPART write
        spart_req = 1; spart_we = 1; spart_addr = 16'h0100; spart_wdata = 32'h0000_00A5;
        t0 = busy_q.size();
        repeat (6) cycle_run();
        n = 0;
        for (int i = t0; i < t0 + 6; i++) if (en_q[i] != 2'b00) n++;
        chk("wr_en_pulses", 64'(n), 64'd1);
        chk("wr_en_we_at", 64'(en_q[t0 + 1]), 64'b11);
        chk("wr_ack_time", 64'(ack_q[t0 + 3]), 64'b010);
        chk("wr_rdata_kept", 64'(rdata_q[t0 + 3]), 64'hDEADBEEF);
        chk("wr_ram", 64'(ram[16'h0100]), 64'h0000_00A5);

        // Three simultaneous requests
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        spart_req = 1; spart_we = 0; spart_addr = 16'h0100;
        audio_req = 1; audio_addr = 16'h0010;
        t0 = busy_q.size();
        repeat (12) cycle_run();
        chk("tri_ack_audio", 64'(ack_q[t0 + 3]), 64'b100);
        chk("tri_ack_spart", 64'(ack_q[t0 + 6]), 64'b010);
        chk("tri_ack_cpu", 64'(ack_q[t0 + 9]), 64'b001);
        chk("tri_busy_audio", 64'(busy_q[t0 + 1]), 64'd3);
        chk("tri_busy_spart", 64'(busy_q[t0 + 4]), 64'd2);
        chk("tri_busy_cpu", 64'(busy_q[t0 + 7]), 64'd1);
        n = 0;
        for (int i = t0 + 1; i <= t0 + 9; i++) if (busy_q[i] == 2'b00) n++;
        chk("tri_no_gap", 64'(n), 64'd0);
        chk("tri_spart_rdata", 64'(rdata_q[t0 + 6]), 64'h0000_00A5);

        // CPU starvation under continuous Audio/SPART traffic
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        spart_req = 1; spart_we = 0; spart_addr = 16'h0030;
        audio_req = 1; audio_addr = 16'h0040;
        t0 = busy_q.size();
        for (int i = 0; i < 18; i++) begin
            cycle_run();
            if (i < 14) begin
                if (!audio_req && !just_acked[2]) audio_req = 1;
                if (!spart_req && !just_acked[1]) spart_req = 1;
            end
        end
        repeat (12) cycle_run();
        n = 0;
        for (int i = t0; i < t0 + 15; i++) if (ack_q[i][0]) n++;
        chk("starve_no_early_cpu", 64'(n), 64'd0);
        chk("starve_cpu_busy", 64'(busy_q[t0 + 13]), 64'd1);
        chk("starve_cpu_ack", 64'(ack_q[t0 + 15]), 64'b001);

        // CPU drops req right after grant
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        t0 = busy_q.size();
        cycle_run();
        cpu_req = 0;
        repeat (5) cycle_run();
        chk("drop_ack_time", 64'(ack_q[t0 + 3]), 64'b001);

        // Reset during the second ACCESS cycle of an Audio read
        audio_req = 1; audio_addr = 16'h0010;
        t0 = busy_q.size();
        cycle_run(); cycle_run();
        rst = 1; audio_req = 0;
        cycle_run();
        rst = 0;
        repeat (4) cycle_run();
        chk("rstmid_busy", 64'(busy_q[t0 + 2]), 64'd0);
        n = 0;
        for (int i = t0 + 2; i < t0 + 7; i++) if (ack_q[i] != 3'b000) n++;
        chk("rstmid_no_ack", 64'(n), 64'd0);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
        t1 = busy_q.size();
        repeat (6) cycle_run();
        chk("rstmid_cpu_ack", 64'(ack_q[t1 + 3]), 64'b001);
        chk("rstmid_cpu_rdata", 64'(rdata_q[t1 + 3]), 64'(model_mem[16'h0020]));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle_run();
            if (!cpu_req && !just_acked[0] && $urandom_range(0, 2) == 0) begin
                cpu_req = 1; cpu_we = 1'($urandom_range(0, 1));
                cpu_addr = 16'($urandom_range(0, 31)); cpu_wdata = $urandom;
            end
            if (!spart_req && !just_acked[1] && $urandom_range(0, 2) == 0) begin
                spart_req = 1; spart_we = 1'($urandom_range(0, 1));
                spart_addr = 16'($urandom_range(0, 31)); spart_wdata = $urandom;
            end
            if (!audio_req && !just_acked[2] && $urandom_range(0, 3) == 0) begin
                audio_req = 1; audio_addr = 16'($urandom_range(0, 31));
            end
        end
        repeat (20) cycle_run();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
